sata_cmd_arbiter: RTL
=====================

SATA_CMD_ARBITER -- requirements
Module: sata_cmd_arbiter

Interface
REQ-001 SHALL have parameter XFER_TIMEOUT, default 32'd150_000_000, XFER-state cycle limit (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports r0_cmd / r1_cmd  input  72 each  requester command {RW, len[22:0], addr[47:0]}; RW = 1 means write.
REQ-005 SHALL have ports r0_req / r1_req  input  1 each  requester command request, level.
REQ-006 SHALL have ports r0_ack / r1_ack  output  1 each  one-cycle command accept pulse.
REQ-007 SHALL have ports usr_cmd  output  72, usr_cmd_req  output  1, usr_cmd_ack  input  1  command port to the SATA wrapper.
REQ-008 SHALL have ports wr_tvalid, wr_tready, wr_teop  input  1 each  write stream toward the wrapper (teop = tuser[0]).
REQ-009 SHALL have ports rd_tvalid, rd_tready, rd_teop  input  1 each  read stream from the wrapper.
REQ-010 SHALL have port grant  output  2  one-hot data-path owner {r1, r0}; 2'b00 = none.
REQ-011 SHALL have ports grant_cnt0 / grant_cnt1  output  32 each  per-requester accepted-command counts.
REQ-012 SHALL have port timeout_cnt  output  32  count of aborted transfers.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, XFER; the reset state SHALL be IDLE.
REQ-015 In IDLE, a single asserted request SHALL be granted; with both asserted, the requester not granted last SHALL win.
- The last-granted pointer resets to r1, so r0 wins the first contention.
REQ-016 On grant, the selected rN_cmd SHALL be registered into usr_cmd.
- Same edge: the matching grant bit and usr_cmd_req SHALL be set and the FSM SHALL move to ISSUE.
- usr_cmd is driven from the register only, never combinationally from rN_cmd.
REQ-017 In ISSUE, usr_cmd_req and usr_cmd SHALL be held stable until usr_cmd_ack = 1.
- On that cycle: usr_cmd_req deasserts next edge, the owner's rN_ack pulses high for exactly one cycle, its grant_cnt increments, the pointer updates, and the FSM moves to XFER.
REQ-018 Requesters SHALL hold rN_req and rN_cmd stable until ack; a requester that drops req before ack is not withdrawn, and its command is still issued.
REQ-019 In XFER, the FSM SHALL return to IDLE on the first transfer-complete handshake (direction from registered RW), and grant SHALL clear on that edge.
- RW = 1: wr_tvalid & wr_tready & wr_teop.
- RW = 0: rd_tvalid & rd_tready & rd_teop.
- EOP handshakes of the opposite direction are ignored.
REQ-020 A new grant SHALL NOT occur in the same cycle XFER exits; IDLE lasts at least one cycle.
- Minimum req-to-usr_cmd_req latency from IDLE: 1 cycle.
REQ-021 A 32-bit XFER cycle counter SHALL clear on XFER entry and increment each XFER cycle.
- If XFER_TIMEOUT != 0 and the counter reaches XFER_TIMEOUT-1 without completion: timeout_cnt increments, grant clears, and the FSM returns to IDLE.
- Completion and timeout in the same cycle count as completion.
REQ-022 All 32-bit counters SHALL wrap from 0xFFFF_FFFF to 0.
REQ-023 usr_cmd_ack outside ISSUE SHALL be ignored.

Reset
REQ-024 On rst_n = 0, all of the following SHALL clear asynchronously: usr_cmd, usr_cmd_req, r0_ack, r1_ack, grant, busy, all counters, and the XFER counter; the state SHALL return to IDLE and the pointer SHALL return to r1.
REQ-025 Reset mid-ISSUE or mid-XFER SHALL abandon the command with no ack pulse.
- The first post-reset grant follows REQ-015.

Verification
REQ-026 Single request: r0_req = 1 with r0_cmd = {1, 23'd16, 48'h100}.
- usr_cmd_req = 1 the next cycle with usr_cmd equal to r0_cmd; ack after 3 cycles gives a single r0_ack pulse and grant_cnt0 = 1.
- wr EOP handshake sets grant = 0 and busy = 0.
REQ-027 Contention: r0 and r1 both request continuously for 4 commands.
- Grant order is r0, r1, r0, r1; grant_cnt0 = grant_cnt1 = 2.
REQ-028 Direction filter: read command (RW = 0) in XFER; a wr EOP handshake is applied first, then a rd EOP handshake.
- The FSM stays in XFER after the wr EOP and exits only on the rd EOP.
REQ-029 Timeout: XFER_TIMEOUT = 10 with no EOP.
- The FSM exits XFER after 10 cycles with timeout_cnt = 1 and grant = 0; XFER_TIMEOUT = 0 never exits.
REQ-030 Reset in XFER: rst_n pulsed low.
- All outputs are 0 immediately; the next contention grants r0.
REQ-031 Wrap: grant_cnt0 preloaded (force) to 0xFFFF_FFFF, then one accepted r0 command.
- grant_cnt0 = 0.

Source files
------------

// File: rtl/sata_cmd_arbiter.sv
// Two-requester command arbiter for a SATA wrapper: round-robin grant in IDLE,
// command handshake in ISSUE, data-path ownership in XFER until EOP or timeout.
module sata_cmd_arbiter #(
  parameter logic [31:0] XFER_TIMEOUT = 32'd150_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] r0_cmd,
  input  logic [71:0] r1_cmd,
  input  logic        r0_req,
  input  logic        r1_req,
  output logic        r0_ack,
  output logic        r1_ack,
  output logic [71:0] usr_cmd,
  output logic        usr_cmd_req,
  input  logic        usr_cmd_ack,
  input  logic        wr_tvalid,
  input  logic        wr_tready,
  input  logic        wr_teop,
  input  logic        rd_tvalid,
  input  logic        rd_tready,
  input  logic        rd_teop,
  output logic [1:0]  grant,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] timeout_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;        // 1: r1 was granted last
  logic [71:0] r_usr_cmd;
  logic        r_usr_cmd_req;
  logic        r_r0_ack;
  logic        r_r1_ack;
  logic [1:0]  r_grant;
  logic [31:0] r_grant_cnt0;
  logic [31:0] r_grant_cnt1;
  logic [31:0] r_timeout_cnt;
  logic [31:0] r_xfer_cnt;

  logic w_grant_en;
  logic w_sel;                // 1: r1 selected
  logic w_ack_en;
  logic w_done;
  logic w_tmo;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_sel       = 1'b0;
    w_ack_en    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r0_req || r1_req) begin
          w_grant_en  = 1'b1;
          w_sel       = (r0_req && r1_req) ? ~r_last : r1_req;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (usr_cmd_ack) begin
          w_ack_en    = 1'b1;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        // Direction comes from the registered RW bit; the other stream's EOP is ignored.
        w_done = r_usr_cmd[71] ? (wr_tvalid && wr_tready && wr_teop)
                               : (rd_tvalid && rd_tready && rd_teop);
        if (w_done) begin
          w_state_nxt = IDLE;
        end else if ((XFER_TIMEOUT != '0) && (r_xfer_cnt == XFER_TIMEOUT - 32'd1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last        <= 1'b1;
      r_usr_cmd     <= '0;
      r_usr_cmd_req <= 1'b0;
      r_r0_ack      <= 1'b0;
      r_r1_ack      <= 1'b0;
      r_grant       <= '0;
      r_grant_cnt0  <= '0;
      r_grant_cnt1  <= '0;
      r_timeout_cnt <= '0;
      r_xfer_cnt    <= '0;
    end else begin
      r_r0_ack <= 1'b0;
      r_r1_ack <= 1'b0;
      if (w_grant_en) begin
        r_usr_cmd     <= w_sel ? r1_cmd : r0_cmd;
        r_usr_cmd_req <= 1'b1;
        r_grant       <= w_sel ? 2'b10 : 2'b01;
      end
      if (w_ack_en) begin
        r_usr_cmd_req <= 1'b0;
        r_xfer_cnt    <= '0;
        r_last        <= r_grant[1];
        if (r_grant[1]) begin
          r_r1_ack     <= 1'b1;
          r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
        end else begin
          r_r0_ack     <= 1'b1;
          r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
        end
      end
      if (r_state == XFER) begin
        if (w_done || w_tmo) begin
          r_grant <= '0;
        end else begin
          r_xfer_cnt <= r_xfer_cnt + 32'd1;
        end
        if (w_tmo) begin
          r_timeout_cnt <= r_timeout_cnt + 32'd1;
        end
      end
    end
  end

  assign usr_cmd     = r_usr_cmd;
  assign usr_cmd_req = r_usr_cmd_req;
  assign r0_ack      = r_r0_ack;
  assign r1_ack      = r_r1_ack;
  assign grant       = r_grant;
  assign grant_cnt0  = r_grant_cnt0;
  assign grant_cnt1  = r_grant_cnt1;
  assign timeout_cnt = r_timeout_cnt;
  assign busy        = (r_state != IDLE);

endmodule
